// File: rtl/vga_fb_fetch.sv
// AXI4 read-burst framebuffer fetcher: issues credit-limited AR bursts and pushes R beats to
// the pixel TX FIFO. Define VGA_FB_DBLBUF_EN for fbba1/fbba2 double-buffer switching.
module vga_fb_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 10,
  parameter int unsigned FRM_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  vbse_i,
  input  logic [ADDR_WIDTH-1:0] fbba1_i,
  input  logic [ADDR_WIDTH-1:0] fbba2_i,
  input  logic [7:0]            brulen_i,
  input  logic [15:0]           line_words_i,
  input  logic [15:0]           frame_lines_i,
  input  logic [CNT_WIDTH-1:0]  fifo_free_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic                  push_valid_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  output logic                  cfb_o,
  output logic                  vbsirq_o,
  output logic                  err_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BSH   = $clog2(BYTES);
  localparam int unsigned SW    = ((CNT_WIDTH > 9) ? CNT_WIDTH : 9) + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StIssue, StFend, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [FRM_WIDTH-1:0]  remaining_q;
  logic [8:0]            len_q;
  logic [7:0]            arlen_q;
  logic [CNT_WIDTH-1:0]  outstanding_q;
  logic                  arvalid_q, rready_q, cfb_q, vbsirq_q, err_q;

  logic                  beat, ar_hs, credit_ok, frame_zero, swap;
  logic [31:0]           frame_words;
  logic [8:0]            calc_len;
  logic [12:0]           bnd_words;
  logic [ADDR_WIDTH-1:0] idle_base, fend_base;
  logic [CNT_WIDTH-1:0]  outstanding_next;

  assign beat        = rvalid_i & rready_q;
  assign ar_hs       = arvalid_q & arready_i;
  assign frame_words = 32'(line_words_i) * 32'(frame_lines_i);
  assign frame_zero  = (FRM_WIDTH'(frame_words) == '0);
  assign credit_ok   = SW'(fifo_free_i) >= (SW'(outstanding_q) + SW'(len_q));

  assign outstanding_next = outstanding_q + (ar_hs ? CNT_WIDTH'(len_q) : '0)
                            - CNT_WIDTH'(beat);

  // Burst length: clipped request, then frame remainder, then words left in the 4 KB page.
  always_comb begin
    calc_len = (brulen_i == 8'd0) ? 9'd1 : {1'b0, brulen_i};
    if (calc_len > 9'(MAX_BURST)) calc_len = 9'(MAX_BURST);
    if (remaining_q < FRM_WIDTH'(calc_len)) calc_len = remaining_q[8:0];
    bnd_words = (13'd4096 - {1'b0, addr_q[11:0]}) >> BSH;
    if (bnd_words < {4'd0, calc_len}) calc_len = bnd_words[8:0];
  end

`ifdef VGA_FB_DBLBUF_EN
  assign swap      = vbse_i;
  assign idle_base = cfb_q ? fbba2_i : fbba1_i;
  assign fend_base = (cfb_q ^ vbse_i) ? fbba2_i : fbba1_i;
  assign cfb_o     = cfb_q;
  assign vbsirq_o  = vbsirq_q;
`else
  assign swap      = 1'b0;
  assign idle_base = fbba1_i;
  assign fend_base = fbba1_i;
  assign cfb_o     = 1'b0;
  assign vbsirq_o  = 1'b0;
  logic unused_dblbuf;
  assign unused_dblbuf = ^{fbba2_i, vbse_i, cfb_q, vbsirq_q};
`endif

  // Beat accounting is count-based, so rlast carries no information here.
  logic unused_rlast;
  assign unused_rlast = rlast_i;

  assign araddr_o     = addr_q;
  assign arlen_o      = arlen_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign push_valid_o = beat & (state_q != StDrain);
  assign push_data_o  = rdata_i;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      arlen_q       <= '0;
      outstanding_q <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cfb_q         <= 1'b0;
      vbsirq_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rready_q      <= 1'b1;
      vbsirq_q      <= 1'b0;
      outstanding_q <= outstanding_next;
      if (beat && (rresp_i != 2'b00)) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            addr_q  <= idle_base;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          remaining_q <= FRM_WIDTH'(frame_words);
          if (!en_i) state_q <= StDrain;
          else if (!frame_zero) state_q <= StCalc;
        end
        StCalc: begin
          len_q   <= calc_len;
          arlen_q <= 8'(calc_len - 9'd1);
          state_q <= en_i ? StIssue : StDrain;
        end
        StIssue: begin
          if (ar_hs) begin
            arvalid_q   <= 1'b0;
            addr_q      <= addr_q + (ADDR_WIDTH'(len_q) << BSH);
            remaining_q <= remaining_q - FRM_WIDTH'(len_q);
            if (!en_i) state_q <= StDrain;
            else if (remaining_q == FRM_WIDTH'(len_q)) state_q <= StFend;
            else state_q <= StCalc;
          end else if (!arvalid_q) begin
            // Once raised, arvalid holds until accepted even if en_i drops.
            if (!en_i) state_q <= StDrain;
            else if (credit_ok) arvalid_q <= 1'b1;
          end
        end
        StFend: begin
          if (!en_i) begin
            state_q <= StDrain;
          end else begin
            if (swap) begin
              cfb_q    <= ~cfb_q;
              vbsirq_q <= 1'b1;
            end
            addr_q  <= fend_base;
            state_q <= StLoad;
          end
        end
        StDrain: begin
          if (outstanding_q == '0) begin
            state_q <= StIdle;
            cfb_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Randomised bench for vga_fb_fetch: an AXI read slave, a pixel FIFO model and a reference
// burst planner derived from frame size, burst clip and 4 KB page rules.
module tb_vga_fb_fetch;
  localparam int AW = 32, DW = 64, CW = 10;
  localparam int MB = 16, BYTES = DW / 8, DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst, en, vbse, arready, rvalid, rlast;
  logic [AW-1:0] fbba1, fbba2, araddr;
  logic [7:0]    brulen, arlen;
  logic [15:0]   line_words, frame_lines;
  logic [CW-1:0] fifo_free;
  logic [DW-1:0] rdata, push_data;
  logic [1:0]    rresp;
  logic          arvalid, rready, push_valid, cfb, vbsirq, err;

  always #5 clk = ~clk;

  vga_fb_fetch dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vbse_i(vbse), .fbba1_i(fbba1), .fbba2_i(fbba2),
    .brulen_i(brulen), .line_words_i(line_words), .frame_lines_i(frame_lines),
    .fifo_free_i(fifo_free), .araddr_o(araddr), .arlen_o(arlen), .arvalid_o(arvalid),
    .arready_i(arready), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
    .rvalid_i(rvalid), .rready_o(rready), .push_valid_o(push_valid),
    .push_data_o(push_data), .cfb_o(cfb), .vbsirq_o(vbsirq), .err_o(err)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  int unsigned   exp_addr[$], exp_len[$];
  int            rq[$];          // beats still owed per accepted burst
  int            occ = 0;        // FIFO occupancy
  int            free_ovr = -1;  // forced fifo_free when >= 0
  int            frames_done, post_dis_ar, total_ar = 0, phase_ar;
  bit            cfb_m, cfb_vis, err_m, draining = 1'b1, r_hold, drop_req, dis_pending;
  bit [1:0]      irq_pipe = '0;
  bit            prev_ok, prev_arvalid = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] prev_addr, first_addr;
  logic [7:0]    prev_len, first_len;

  // One frame of bursts planned straight from the address arithmetic.
  task automatic gen_frame();
    int unsigned a, rem, b, bw, len;
    a   = cfb_m ? fbba2 : fbba1;
    rem = int'(line_words) * int'(frame_lines);
    b   = (brulen == 0) ? 1 : ((brulen > MB) ? MB : brulen);
    while (rem > 0) begin
      bw  = (4096 - (a % 4096)) / BYTES;
      len = b;
      if (rem < len) len = rem;
      if (bw < len) len = bw;
      exp_addr.push_back(a);
      exp_len.push_back(len);
      a   += len * BYTES;
      rem -= len;
    end
  endtask

  task automatic step();
    bit beat, pop, hs, last, just_dropped;
    int owed;
    @(posedge clk);
    #1;
    just_dropped = 1'b0;
    if (drop_req && irq_pipe == 2'b00) begin
      en = 1'b0; draining = 1'b1; drop_req = 1'b0; just_dropped = 1'b1;
    end
    pop       = (occ > 0) && ($urandom_range(0, 99) < 50);
    fifo_free = (free_ovr >= 0) ? CW'(free_ovr) : CW'(DEPTH - occ);
    arready   = draining || ($urandom_range(0, 99) < 60);
    beat      = !r_hold && (rq.size() > 0) && ($urandom_range(0, 99) < 75);
    rvalid    = beat;
    rdata     = {$urandom(), $urandom()};
    rresp     = (beat && $urandom_range(0, 19) == 0) ? 2'b10 : 2'b00;
    rlast     = 1'b0;
    if (beat) rlast = (rq[0] == 1);
    #1;
    if (just_dropped) dis_pending = arvalid;
    hs = arvalid && arready;

    check_eq("push_valid", push_valid, beat && !draining);
    if (beat && !draining) check_eq("push_data", push_data, rdata);
    if (push_valid) check_eq("fifo_room", occ < DEPTH, 1'b1);
    if (prev_stall) begin
      check_eq("ar_hold", arvalid, 1'b1);
      check_eq("ar_addr_stable", araddr, prev_addr);
      check_eq("ar_len_stable", arlen, prev_len);
    end
    if (arvalid && !prev_arvalid) check_eq("ar_credit", prev_ok, 1'b1);
    if (!draining) begin
      if (irq_pipe[1]) cfb_vis = !cfb_vis;
      check_eq("vbsirq", vbsirq, irq_pipe[1]);
      check_eq("cfb", cfb, cfb_vis);
      check_eq("err", err, err_m);
    end

    owed = 0;
    foreach (rq[i]) owed += rq[i];
    prev_ok      = int'(fifo_free) >= owed + ((exp_len.size() > 0) ? int'(exp_len[0]) : 0);
    prev_arvalid = arvalid;
    prev_stall   = arvalid && !arready;
    prev_addr    = araddr;
    prev_len     = arlen;

    last = 1'b0;
    if (hs) begin
      total_ar++;
      if (draining) post_dis_ar++;
      check_eq("ar_expected", exp_len.size() > 0, 1'b1);
      if (exp_len.size() > 0) begin
        check_eq("ar_addr", araddr, exp_addr[0]);
        check_eq("ar_len", arlen, exp_len[0] - 1);
        if (phase_ar == 0) begin first_addr = araddr; first_len = arlen; end
        phase_ar++;
        rq.push_back(exp_len[0]);
        void'(exp_addr.pop_front());
        void'(exp_len.pop_front());
        if (exp_len.size() == 0 && !draining) begin
          frames_done++;
`ifdef VGA_FB_DBLBUF_EN
          if (vbse) begin cfb_m = !cfb_m; last = 1'b1; end
`endif
          gen_frame();
        end
      end
    end
    irq_pipe = {irq_pipe[0], last};
    if (beat) begin
      rq[0] = rq[0] - 1;
      if (rq[0] == 0) void'(rq.pop_front());
      if (rresp != 2'b00) err_m = 1'b1;
    end
    occ = occ + int'(push_valid) - int'(pop);
  endtask

  task automatic run_phase(input logic [31:0] b1, input logic [31:0] b2, input int bl,
                           input int lw, input int fl, input bit vb, input int nframes,
                           input bit ovr);
    int cyc, ar_before;
    fbba1 = b1; fbba2 = b2; brulen = 8'(bl);
    line_words = 16'(lw); frame_lines = 16'(fl); vbse = vb;
    cfb_m = 1'b0; cfb_vis = 1'b0; err_m = 1'b0; frames_done = 0; post_dis_ar = 0;
    phase_ar = 0; dis_pending = 1'b0;
    exp_addr.delete(); exp_len.delete();
    gen_frame();
    free_ovr = ovr ? 10 : -1;
    en = 1'b1; r_hold = 1'b0; draining = 1'b0;
    if (ovr) begin
      repeat (20) step();
      check_eq("credit_block", arvalid, 1'b0);
      free_ovr = 16; ar_before = total_ar; cyc = 0;
      while (total_ar == ar_before && cyc < 40) begin step(); cyc++; end
      check_eq("credit_release", total_ar - ar_before, 1);
      free_ovr = -1;
    end
    if (lw * fl == 0) begin
      repeat (20) step();
      check_eq("zero_frame_no_ar", arvalid, 1'b0);
    end else begin
      cyc = 0;
      while (frames_done < nframes && cyc < 20000) begin step(); cyc++; end
      check_eq("frames", frames_done, nframes);
    end
    // Let bursts pile up unanswered, then disable with beats outstanding.
    r_hold = 1'b1;
    repeat ($urandom_range(4, 30)) step();
    drop_req = 1'b1; cyc = 0;
    while (drop_req && cyc < 100) begin step(); cyc++; end
    if (drop_req) begin en = 1'b0; draining = 1'b1; drop_req = 1'b0; end
    repeat (3) step();
    r_hold = 1'b0; cyc = 0;
    while (rq.size() > 0 && cyc < 3000) begin step(); cyc++; end
    check_eq("drain_beats_left", rq.size(), 0);
    repeat (4) step();
    check_eq("idle_arvalid", arvalid, 1'b0);
    check_eq("idle_cfb", cfb, 1'b0);
    check_eq("idle_err", err, 1'b0);
    check_eq("dis_ar_count", post_dis_ar, dis_pending);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vbse = 1'b0; fbba1 = '0; fbba2 = '0; brulen = '0;
    line_words = '0; frame_lines = '0; fifo_free = '0; arready = 1'b0;
    rvalid = 1'b1; rdata = '1; rresp = 2'b10; rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arvalid", arvalid, 1'b0);
    check_eq("rst_araddr", araddr, '0);
    check_eq("rst_arlen", arlen, '0);
    check_eq("rst_rready", rready, 1'b0);
    check_eq("rst_push", push_valid, 1'b0);
    check_eq("rst_cfb", cfb, 1'b0);
    check_eq("rst_vbsirq", vbsirq, 1'b0);
    check_eq("rst_err", err, 1'b0);
    rst = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    step();
    check_eq("rready_after_rst", rready, 1'b1);

    run_phase(32'h1000, 32'h8000, 16, 40, 2, 1'b1, 2, 1'b0);
    check_eq("tp_first_addr", first_addr, 32'h1000);
    check_eq("tp_first_len", first_len, 8'd15);
    run_phase(32'h1FC0, 32'h8000, 16, 40, 1, 1'b0, 1, 1'b0);
    check_eq("tp_page_addr", first_addr, 32'h1FC0);
    check_eq("tp_page_len", first_len, 8'd7);
    run_phase(32'h1000, 32'h8000, 16, 40, 2, 1'b0, 1, 1'b1);
    run_phase(32'h3000, 32'h8000, 8, 0, 5, 1'b1, 1, 1'b0);
    run_phase(32'h2FF8, 32'h5000, 0, 3, 1, 1'b1, 3, 1'b0);
    for (int p = 0; p < 8; p++) begin
      run_phase(32'(($urandom_range(1, 14) << 12) + $urandom_range(0, 511) * BYTES),
                32'(($urandom_range(1, 14) << 12) + $urandom_range(0, 511) * BYTES),
                int'($urandom_range(0, 40)), int'($urandom_range(1, 50)),
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(2, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
